// File: rtl/mul_arbiter.sv
// -----------------------------------------------------------------------------
// mul_arbiter
//
// Shares one external multiplier among NUM_REQ clients. Each client posts a
// one-cycle request with its operands, which are captured into a private slot.
// A round-robin FSM serves one slot at a time: it issues the operands to the
// multiplier, waits for the multiplier's completion pulse, writes the product
// into that client's result slot and pulses the client's ack.
//
// Ports
//   clk      : single clock, rising edge active
//   rst      : asynchronous active-high reset
//   req      : per-client one-cycle request pulse
//   a, b     : per-client operands, client i in bits [i*WIDTH +: WIDTH]
//   ack      : per-client one-cycle completion pulse (at most one bit high)
//   out      : per-client result slots, same packing as a
//   busy     : per-client request pending or in flight
//   mul_req  : one-cycle request pulse to the shared multiplier
//   mul_a/b  : operands to the multiplier, stable while an operation is open
//   mul_ack  : multiplier completion pulse
//   mul_out  : multiplier result, valid with mul_ack
// -----------------------------------------------------------------------------
module mul_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] a,
    input  logic [NUM_REQ*WIDTH-1:0] b,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ*WIDTH-1:0] out,
    output logic [NUM_REQ-1:0]       busy,
    output logic                     mul_req,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic                     mul_ack,
    input  logic [WIDTH-1:0]         mul_out
);

    localparam int              IDXW     = $clog2(NUM_REQ);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    state_t                   state_r;
    state_t                   state_s;

    logic [NUM_REQ-1:0]       pending_r;
    logic [NUM_REQ-1:0]       busy_r;
    logic [NUM_REQ-1:0]       ack_r;
    logic [NUM_REQ-1:0]       capture_s;

    logic [WIDTH-1:0]         slot_a_r [NUM_REQ];
    logic [WIDTH-1:0]         slot_b_r [NUM_REQ];
    logic [NUM_REQ*WIDTH-1:0] out_r;

    logic                     mul_req_r;
    logic [WIDTH-1:0]         mul_a_r;
    logic [WIDTH-1:0]         mul_b_r;

    logic [IDXW-1:0]          grant_r;
    logic [IDXW-1:0]          last_grant_r;
    logic [IDXW-1:0]          grant_s;
    logic [IDXW-1:0]          cand_s;
    logic                     found_s;

    logic                     load_grant_s;
    logic                     clear_pend_s;
    logic                     latch_out_s;
    logic                     finish_s;

    // One-hot vector with the bit for client idx set.
    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDXW-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            vec[i] = (idx == IDXW'(i));
        end
        return vec;
    endfunction

    // Request acceptance: a client that is idle, or is being acked this very
    // cycle, may post a new request.
    always_comb begin
        capture_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            capture_s[i] = req[i] & (~busy_r[i] | ack_r[i]);
        end
    end

    // Round-robin search: first pending client after the last one served.
    always_comb begin
        found_s = 1'b0;
        grant_s = '0;
        cand_s  = last_grant_r;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (cand_s == LAST_IDX) begin
                cand_s = '0;
            end else begin
                cand_s = cand_s + IDXW'(1);
            end
            if (!found_s && pending_r[cand_s]) begin
                found_s = 1'b1;
                grant_s = cand_s;
            end else begin
                // an earlier candidate already won, or this one is not pending
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state and per-state action strobes.
    always_comb begin
        state_s      = state_r;
        load_grant_s = 1'b0;
        clear_pend_s = 1'b0;
        latch_out_s  = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_s      = ST_ISSUE;
                    load_grant_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s      = ST_WAIT;
                clear_pend_s = 1'b1;
            end
            ST_WAIT: begin
                // mul_ack is only honoured here; elsewhere it is stray
                if (mul_ack) begin
                    state_s     = ST_RESPOND;
                    latch_out_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESPOND: begin
                state_s  = ST_IDLE;
                finish_s = 1'b1;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control registers: grant, multiplier interface, ack, pending and busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_r      <= '0;
            last_grant_r <= LAST_IDX;
            mul_req_r    <= 1'b0;
            mul_a_r      <= '0;
            mul_b_r      <= '0;
            ack_r        <= '0;
            pending_r    <= '0;
            busy_r       <= '0;
        end else begin
            // mul_req and ack are registered images of the state being entered,
            // so each is high for exactly the one ISSUE / RESPOND cycle
            mul_req_r <= (state_s == ST_ISSUE);
            ack_r     <= latch_out_s ? idx_onehot(grant_r) : '0;

            if (load_grant_s) begin
                grant_r <= grant_s;
                mul_a_r <= slot_a_r[grant_s];
                mul_b_r <= slot_b_r[grant_s];
            end

            if (finish_s) begin
                last_grant_r <= grant_r;
            end

            for (int i = 0; i < NUM_REQ; i++) begin
                if (capture_s[i]) begin
                    pending_r[i] <= 1'b1;
                end else if (clear_pend_s && (grant_r == IDXW'(i))) begin
                    pending_r[i] <= 1'b0;
                end

                // a re-request in the ack cycle keeps the client busy
                if (capture_s[i]) begin
                    busy_r[i] <= 1'b1;
                end else if (finish_s && (grant_r == IDXW'(i))) begin
                    busy_r[i] <= 1'b0;
                end
            end
        end
    end

    // Operand slots and result slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_a_r[i] <= '0;
                slot_b_r[i] <= '0;
            end
            out_r <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (capture_s[i]) begin
                    slot_a_r[i] <= a[i*WIDTH +: WIDTH];
                    slot_b_r[i] <= b[i*WIDTH +: WIDTH];
                end
                // result slot only changes on this client's completion
                if (latch_out_s && (grant_r == IDXW'(i))) begin
                    out_r[i*WIDTH +: WIDTH] <= mul_out;
                end
            end
        end
    end

    assign ack     = ack_r;
    assign out     = out_r;
    assign busy    = busy_r;
    assign mul_req = mul_req_r;
    assign mul_a   = mul_a_r;
    assign mul_b   = mul_b_r;

endmodule

// File: tb/tb_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mul_arbiter
//
// Scoreboard bench for mul_arbiter. Stimulus pushes the expected (client,
// result) pair for every request it expects to be served; a monitor pops one
// entry per ack and compares the ack bit and the client's result slot. A
// behavioural multiplier with programmable latency answers mul_req and flags
// any second mul_req while one is outstanding.
// -----------------------------------------------------------------------------
module tb_mul_arbiter;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] a;
    logic [NUM_REQ*WIDTH-1:0] b;
    logic [NUM_REQ-1:0]       ack;
    logic [NUM_REQ*WIDTH-1:0] out;
    logic [NUM_REQ-1:0]       busy;
    logic                     mul_req;
    logic [WIDTH-1:0]         mul_a;
    logic [WIDTH-1:0]         mul_b;
    logic                     mul_ack;
    logic [WIDTH-1:0]         mul_out;

    mul_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .a       (a),
        .b       (b),
        .ack     (ack),
        .out     (out),
        .busy    (busy),
        .mul_req (mul_req),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_ack (mul_ack),
        .mul_out (mul_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               client;
        logic [WIDTH-1:0] value;
    } exp_t;

    exp_t             exp_q[$];
    int               checks   = 0;
    int               passes   = 0;
    int               mul_lat  = 1;
    int               mul_cnt  = 0;
    int               mul_reqs = 0;
    int               ack_seen = 0;
    logic [WIDTH-1:0] pa;
    logic [WIDTH-1:0] pb;
    int               sent[NUM_REQ];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int c, input logic [WIDTH-1:0] v);
        exp_t e;
        e.client = c;
        e.value  = v;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int c, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        req[c]              = 1'b1;
        a[c*WIDTH +: WIDTH] = av;
        b[c*WIDTH +: WIDTH] = bv;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ack"},     64'(ack),     64'd0);
        chk({tag, "_busy"},    64'(busy),    64'd0);
        chk({tag, "_mul_req"}, 64'(mul_req), 64'd0);
        chk({tag, "_mul_a"},   64'(mul_a),   64'd0);
        chk({tag, "_mul_b"},   64'(mul_b),   64'd0);
        for (int i = 0; i < NUM_REQ; i++) begin
            chk($sformatf("%s_out%0d", tag, i), 64'(out[i*WIDTH +: WIDTH]), 64'd0);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        #1;
        check_outputs_zero(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain_left"}, 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    // Behavioural multiplier: answers each mul_req after mul_lat cycles.
    initial begin
        mul_ack = 1'b0;
        mul_out = '0;
        forever begin
            @(negedge clk);
            if (mul_ack) begin
                mul_ack = 1'b0;
                mul_out = '0;
            end
            if (mul_cnt > 0) begin
                mul_cnt--;
                if (mul_cnt == 0) begin
                    mul_ack = 1'b1;
                    mul_out = pa * pb;
                end
            end
            if (mul_req) begin
                chk("mul_req_single_outstanding", 64'(mul_cnt == 0 && !mul_ack), 64'd1);
                mul_reqs++;
                pa      = mul_a;
                pb      = mul_b;
                mul_cnt = mul_lat;
            end
        end
    end

    // Monitor: every ack is matched against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack !== '0) begin
                ack_seen++;
                if (exp_q.size() == 0) begin
                    chk("ack_unexpected", 64'(ack), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("ack_client%0d", e.client), 64'(ack), 64'd1 << e.client);
                    chk($sformatf("out_client%0d", e.client),
                        64'(out[e.client*WIDTH +: WIDTH]), 64'(e.value));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] wa[3];
        logic [WIDTH-1:0] wb[3];
        logic [WIDTH-1:0] wr[3];
        int acks;
        int n;
        int done;
        int m0;
        int a0;

        rst = 1'b1;
        req = '0;
        a   = '0;
        b   = '0;

        // ---- single client 3*5 ----
        do_reset("rst1");
        @(negedge clk);
        set_req(0, 32'd3, 32'd5);
        push_exp(0, 32'd15);
        @(negedge clk);
        req = '0;
        chk("t1_idle_no_mul_req", 64'(mul_req), 64'd0);
        chk("t1_busy_set", 64'(busy[0]), 64'd1);
        @(negedge clk);
        chk("t1_mul_req_2_after_req", 64'(mul_req), 64'd1);
        chk("t1_mul_a", 64'(mul_a), 64'd3);
        chk("t1_mul_b", 64'(mul_b), 64'd5);
        @(negedge clk);
        chk("t1_mul_req_one_cycle", 64'(mul_req), 64'd0);
        @(negedge clk);
        chk("t1_ack_after_mul_ack", 64'(ack), 64'd1);
        @(negedge clk);
        chk("t1_busy_clear", 64'(busy[0]), 64'd0);
        chk("t1_ack_one_cycle", 64'(ack), 64'd0);
        drain("t1", 20);

        // ---- contention, clients 0 and 2 together ----
        do_reset("rst2");
        @(negedge clk);
        set_req(0, 32'd15, 32'd4);
        set_req(2, 32'd150, 32'd40);
        push_exp(0, 32'd60);
        push_exp(2, 32'd6000);
        @(negedge clk);
        req = '0;
        drain("t2", 100);
        chk("t2_busy_clear", 64'(busy), 64'd0);

        // ---- fairness, continuous re-request ----
        do_reset("rst3");
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, WIDTH'(i + 1), 32'd2);
            sent[i] = 1;
        end
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                push_exp(i, WIDTH'((i + 1) * (k + 2)));
            end
        end
        acks = 0;
        n    = 0;
        while (acks < 12 && n < 400) begin
            @(negedge clk);
            n++;
            req = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ack[i]) begin
                    acks++;
                    if (sent[i] < 3) begin
                        set_req(i, WIDTH'(i + 1), WIDTH'(sent[i] + 2));
                        sent[i]++;
                    end
                end
            end
        end
        chk("t3_ack_count", 64'(acks), 64'd12);
        drain("t3", 20);

        // ---- request while busy is ignored ----
        do_reset("rst4");
        m0 = mul_reqs;
        @(negedge clk);
        set_req(1, 32'd7, 32'd3);
        push_exp(1, 32'd21);
        @(negedge clk);
        req = '0;
        set_req(1, 32'd9, 32'd9);
        @(negedge clk);
        req = '0;
        drain("t4", 50);
        repeat (10) @(negedge clk);
        chk("t4_single_mul_req", 64'(mul_reqs - m0), 64'd1);
        chk("t4_busy_clear", 64'(busy[1]), 64'd0);
        chk("t4_out_held", 64'(out[1*WIDTH +: WIDTH]), 64'd21);

        // ---- back-to-back in the ack cycle, large and wrapping products ----
        wa = '{32'd347911, 32'd9556, 32'd65536};
        wb = '{32'd12345, 32'd124, 32'd65537};
        wr = '{32'd4294961295, 32'd1184944, 32'd65536};
        do_reset("rst5");
        @(negedge clk);
        set_req(3, wa[0], wb[0]);
        for (int k = 0; k < 3; k++) begin
            push_exp(3, wr[k]);
        end
        done = 0;
        n    = 0;
        while (done < 3 && n < 200) begin
            @(negedge clk);
            n++;
            req = '0;
            if (ack[3]) begin
                done++;
                if (done < 3) begin
                    set_req(3, wa[done], wb[done]);
                end
            end
        end
        chk("t5_ack_count", 64'(done), 64'd3);
        drain("t5", 20);
        chk("t5_busy_clear", 64'(busy[3]), 64'd0);

        // ---- reset while waiting on the multiplier ----
        do_reset("rst6");
        mul_lat = 6;
        @(negedge clk);
        set_req(0, 32'd3, 32'd5);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        chk("t6_mul_req", 64'(mul_req), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_zero("t6_in_wait");
        @(negedge clk);
        rst = 1'b0;
        a0 = ack_seen;
        repeat (8) @(negedge clk);
        chk("t6_no_ack_after_stray", 64'(ack_seen - a0), 64'd0);
        chk("t6_busy_idle", 64'(busy), 64'd0);
        mul_lat = 1;
        @(negedge clk);
        set_req(0, 32'd3, 32'd5);
        push_exp(0, 32'd15);
        @(negedge clk);
        req = '0;
        drain("t6", 30);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
